// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing the EX-stage ALU (port 0 = pipeline, port 1 = aux sequencer).
// Optional port-1 anti-starvation aging is enabled by defining ALU_ARB_AGING_EN.
module alu_share_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             lock1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] alu_res,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             gnt0,
  output logic             gnt1,
  output logic             stall0,
  output logic             vld0,
  output logic             vld1,
  output logic [WIDTH-1:0] res0,
  output logic [WIDTH-1:0] res1
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_LOCK1 = 1'b1;
  localparam logic [2:0] OP_NOP  = 3'b011;

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("alu_share_arbiter: MAX_WAIT must be in 1..15");
  end

  logic [0:0]       state_q, state_d;
  logic             vld0_q, vld1_q;
  logic [WIDTH-1:0] res0_q, res1_q;
  logic             force1;
  logic             g0, g1;

`ifdef ALU_ARB_AGING_EN
  logic [3:0] wait1_q, wait1_d;

  assign force1 = (wait1_q == 4'(MAX_WAIT));

  // Count cycles port 1 is left waiting; saturate so the forced grant holds until taken
  always_comb begin
    wait1_d = 4'd0;
    if (req1 && !g1) begin
      wait1_d = force1 ? wait1_q : wait1_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait1_q <= 4'd0;
    end else begin
      wait1_q <= wait1_d;
    end
  end
`else
  assign force1 = 1'b0;
`endif

  // Grant selection and lock FSM; reset masks every grant in the same cycle
  always_comb begin
    state_d = state_q;
    g0      = 1'b0;
    g1      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (req1 && (!req0 || force1)) begin
            g1 = 1'b1;
          end else if (req0) begin
            g0 = 1'b1;
          end
          if (g1 && lock1) begin
            state_d = S_LOCK1;
          end
        end
        S_LOCK1: begin
          g1 = req1;
          if (!(req1 && lock1)) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      vld0_q  <= g0;
      vld1_q  <= g1;
      if (g0) begin
        res0_q <= alu_res;
      end
      if (g1) begin
        res1_q <= alu_res;
      end
    end
  end

  // Operand mux toward the shared ALU
  always_comb begin
    alu_op = OP_NOP;
    alu_a  = '0;
    alu_b  = '0;
    if (g1) begin
      alu_op = op1;
      alu_a  = a1;
      alu_b  = b1;
    end else if (g0) begin
      alu_op = op0;
      alu_a  = a0;
      alu_b  = b0;
    end
  end

  assign gnt0   = g0;
  assign gnt1   = g1;
  assign stall0 = !rst && req0 && !g0;
  assign vld0   = vld0_q;
  assign vld1   = vld1_q;
  assign res0   = res0_q;
  assign res1   = res1_q;

endmodule
